// File: rtl/bcd_to_7_seg.sv
// Registered BCD-to-seven-segment decoder driving one fixed digit of a
// multiplexed display; seg/an are flopped with no combinational path from bcd.
module bcd_to_7_seg #(
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1,
  parameter int unsigned DIGIT_SEL      = 0,
  parameter int unsigned INVALID_MODE   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] bcd,
  output logic [6:0] seg,
  output logic [3:0] an
);

  localparam logic [1:0] SEL_IDX   = 2'(DIGIT_SEL);
  localparam logic [3:0] AN_ONEHOT = 4'b0001 << SEL_IDX;
  localparam logic [6:0] SEG_OFF   = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [3:0] AN_OFF    = AN_ACTIVE_LOW ? 4'hF : 4'h0;
  localparam logic [3:0] AN_ON     = AN_ACTIVE_LOW ? ~AN_ONEHOT : AN_ONEHOT;

  logic [6:0] lit_d;
  logic [6:0] hex_lit;
  logic [6:0] seg_d, seg_q;
  logic [3:0] an_q;

  // lit_d is active-high, bit 0 = segment a ... bit 6 = segment g
  always_comb begin
    hex_lit = 7'h00;
    case (bcd)
      4'd10:   hex_lit = 7'h77;
      4'd11:   hex_lit = 7'h7C;
      4'd12:   hex_lit = 7'h39;
      4'd13:   hex_lit = 7'h5E;
      4'd14:   hex_lit = 7'h79;
      4'd15:   hex_lit = 7'h71;
      default: hex_lit = 7'h00;
    endcase
  end

  always_comb begin
    lit_d = 7'h00;
    case (bcd)
      4'd0: lit_d = 7'h3F;
      4'd1: lit_d = 7'h06;
      4'd2: lit_d = 7'h5B;
      4'd3: lit_d = 7'h4F;
      4'd4: lit_d = 7'h66;
      4'd5: lit_d = 7'h6D;
      4'd6: lit_d = 7'h7D;
      4'd7: lit_d = 7'h07;
      4'd8: lit_d = 7'h7F;
      4'd9: lit_d = 7'h6F;
      default: begin
        if (INVALID_MODE == 0)      lit_d = 7'h00;
        else if (INVALID_MODE == 2) lit_d = hex_lit;
        else                        lit_d = 7'h40;
      end
    endcase
  end

  assign seg_d = SEG_ACTIVE_LOW ? ~lit_d : lit_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= SEG_OFF;
      an_q  <= AN_OFF;
    end else begin
      seg_q <= seg_d;
      an_q  <= AN_ON;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule

// File: tb/tb_bcd_to_7_seg.sv
// Directed bench for bcd_to_7_seg: default build plus hex-mode, blank-mode
// and inverted-polarity/digit-2 builds sharing the same stimulus.
module tb_bcd_to_7_seg;

  logic       clk = 1'b0;
  logic       clk_run = 1'b1;
  logic       rst_n;
  logic [3:0] bcd;
  logic [6:0] seg_def, seg_hex, seg_blk, seg_pol;
  logic [3:0] an_def, an_hex, an_blk, an_pol;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = clk_run ? ~clk : clk;

  bcd_to_7_seg u_def (.clk(clk), .rst_n(rst_n), .bcd(bcd), .seg(seg_def), .an(an_def));

  bcd_to_7_seg #(.INVALID_MODE(2)) u_hex (
    .clk(clk), .rst_n(rst_n), .bcd(bcd), .seg(seg_hex), .an(an_hex));

  bcd_to_7_seg #(.INVALID_MODE(0)) u_blk (
    .clk(clk), .rst_n(rst_n), .bcd(bcd), .seg(seg_blk), .an(an_blk));

  bcd_to_7_seg #(.SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0), .DIGIT_SEL(2)) u_pol (
    .clk(clk), .rst_n(rst_n), .bcd(bcd), .seg(seg_pol), .an(an_pol));

  task automatic chk7(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // apply a code on the falling edge, then sample 1ns after the next rising edge
  task automatic apply(input logic [3:0] v);
    @(negedge clk);
    bcd = v;
    @(posedge clk);
    #1;
  endtask

  logic [6:0] sweep_exp [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  logic [3:0] inv_code [3] = '{4'd10, 4'd11, 4'd14};
  logic [6:0] inv_hex  [3] = '{7'h08, 7'h03, 7'h06};

  initial begin
    rst_n = 1'b0;
    bcd   = 4'b1000;
    repeat (3) @(posedge clk);
    #1;
    chk7("rst_seg_def", seg_def, 7'h7F);
    chk4("rst_an_def",  an_def,  4'hF);
    chk7("rst_seg_hex", seg_hex, 7'h7F);
    chk7("rst_seg_blk", seg_blk, 7'h7F);
    chk7("rst_seg_pol", seg_pol, 7'h00);
    chk4("rst_an_pol",  an_pol,  4'h0);

    @(negedge clk);
    rst_n = 1'b1;
    bcd   = 4'd0;
    #1;
    chk7("release_before_edge", seg_def, 7'h7F);
    chk4("release_an_before_edge", an_def, 4'hF);

    for (int i = 0; i < 10; i++) begin
      apply(4'(i));
      chk7($sformatf("sweep_seg_%0d", i), seg_def, sweep_exp[i]);
      chk4($sformatf("sweep_an_%0d", i), an_def, 4'b1110);
    end

    apply(4'b0001);
    chk7("lat_seg_1", seg_def, 7'h79);
    bcd = 4'b0011;
    #2;
    chk7("lat_hold", seg_def, 7'h79);
    @(posedge clk);
    #1;
    chk7("lat_update", seg_def, 7'h30);

    for (int i = 0; i < 3; i++) begin
      apply(inv_code[i]);
      chk7($sformatf("inv_dash_%0d", inv_code[i]), seg_def, 7'h3F);
      chk4($sformatf("inv_an_%0d", inv_code[i]), an_def, 4'b1110);
      chk7($sformatf("inv_hex_%0d", inv_code[i]), seg_hex, inv_hex[i]);
      chk7($sformatf("inv_blank_%0d", inv_code[i]), seg_blk, 7'h7F);
      chk4($sformatf("inv_blank_an_%0d", inv_code[i]), an_blk, 4'b1110);
    end
    apply(4'd12);
    chk7("hex_C", seg_hex, 7'h46);
    apply(4'd13);
    chk7("hex_d", seg_hex, 7'h21);
    apply(4'd15);
    chk7("hex_F", seg_hex, 7'h0E);

    apply(4'b0110);
    chk7("pol_seg_6", seg_pol, 7'h7D);
    chk4("pol_an",    an_pol,  4'b0100);
    chk7("def_seg_6", seg_def, 7'h02);

    apply(4'd8);
    chk7("show_8", seg_def, 7'h00);
    @(negedge clk);
    clk_run = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk7("midrst_seg_def", seg_def, 7'h7F);
    chk4("midrst_an_def",  an_def,  4'hF);
    chk7("midrst_seg_pol", seg_pol, 7'h00);
    chk4("midrst_an_pol",  an_pol,  4'h0);
    bcd = 4'b0011;
    #2;
    rst_n = 1'b1;
    #2;
    chk7("midrst_released_no_edge", seg_def, 7'h7F);
    clk_run = 1'b1;
    @(posedge clk);
    #1;
    chk7("midrst_first_edge", seg_def, 7'h30);
    chk4("midrst_first_edge_an", an_def, 4'b1110);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bcd_to_7_seg.md
Name: bcd_to_7_seg

Overview:
- Registered BCD-to-seven-segment decoder for a single digit of a 4-digit multiplexed display, such as a common-anode board display.
- Converts a 4-bit BCD code into segment drive levels and enables one fixed digit anode.
- Non-BCD codes 10–15 are flagged visibly rather than silently decoded.
- Sits between the digit-value logic and the board display pins.

Parameters:
- SEG_ACTIVE_LOW, 1: 1 means a lit segment is driven 0; 0 means a lit segment is driven 1.
- AN_ACTIVE_LOW, 1: 1 means the enabled anode is driven 0; 0 means it is driven 1.
- DIGIT_SEL, 0: index (0–3) of the anode enabled during normal operation.
- INVALID_MODE, 1: display for codes 10–15. 0 = blank, 1 = dash (segment g only), 2 = hex glyphs A b C d E F.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low; one clock; reset is asynchronous and active-low.
- bcd  input  4  digit code to display.
- seg  output  7  segment drive; seg[0]=a, seg[1]=b, … seg[6]=g.
- an  output  4  digit anode enables; an[i] drives digit i.
- Port order: clk, rst_n, bcd, seg, an.

Behaviour:
- Structure: one register stage. bcd is decoded combinationally; seg and an are registered outputs with no combinational path from bcd.
- Latency: 1 cycle. The value on bcd at rising edge N appears on seg/an after edge N and holds until the next edge.
- Reset: asserting rst_n=0 immediately, without a clock, forces all segments off and all anodes off.
  - With default parameters: seg=7'h7F, an=4'hF.
- Release of reset: deassertion is clock-independent. Outputs stay off until the first rising edge with rst_n=1, which loads the current decode.
- Reset mid-operation: outputs clear at once. No history is retained.
- Anodes after reset: only bit DIGIT_SEL is active; the other three bits are inactive. This holds every cycle, including when the glyph is blank.
  - Default: an=4'b1110.
- Segment table, lit segments for codes 0–9:
  - 0: a b c d e f
  - 1: b c
  - 2: a b d e g
  - 3: a b c d g
  - 4: b c f g
  - 5: a c d f g
  - 6: a c d e f g
  - 7: a b c
  - 8: all seven segments
  - 9: a b c d f g
- Active-low seg encodings with defaults, codes 0–9 in order: 40, 79, 24, 30, 19, 12, 02, 78, 00, 10 (hex).
- Codes 10–15, per INVALID_MODE:
  - mode 0: blank, 7F.
  - mode 1: dash, 3F.
  - mode 2: A=08, b=03, C=46, d=21, E=06, F=0E.
  - Any other INVALID_MODE value behaves as mode 1.
- Polarity: with SEG_ACTIVE_LOW=0 the seg value is the bitwise inverse of the table, reset value included. With AN_ACTIVE_LOW=0 the an value is the bitwise inverse, reset value included.
- X or Z on bcd: must not corrupt state held in reset. Outside reset, behaviour is don't-care.
- Back-to-back changes: every clock samples bcd anew. No hold or debounce.

Test Plan:
- Reset: hold rst_n=0 with bcd=4'b1000 over several clocks → seg=7'h7F, an=4'hF. Assert rst_n mid-cycle with the clock stopped → outputs clear immediately.
- Digit sweep: release reset, apply bcd 0–9 one per clock → seg follows 40, 79, 24, 30, 19, 12, 02, 78, 00, 10, each one cycle after applying. an=4'b1110 throughout.
- Latency check: change bcd from 0001 to 0011 just after an edge → seg stays 79 until the next edge, then becomes 30.
- Invalid codes, defaults: bcd=1010, 1011, 1110 → seg=3F each, an=4'b1110.
  - With INVALID_MODE=2: 08, 03, 06.
  - With INVALID_MODE=0: 7F.
- Polarity and digit selection: SEG_ACTIVE_LOW=0, AN_ACTIVE_LOW=0, DIGIT_SEL=2, bcd=0110 → seg=7'h7D, an=4'b0100. During reset → seg=00, an=0000.
- Mid-run reset: assert rst_n=0 while showing 8 → seg=7F at once. Release with bcd=0011 → 30 after the first edge.
